// File: rtl/uart_axi_master_if.sv
// AXI4-lite bus between the UART register bridge and the UART slave.
// Only the low byte of the data channels carries UART traffic.
interface uart_axi_master_if;
    logic [3:0]  uart_axi_araddr;
    logic        uart_axi_arvalid;
    logic        uart_axi_arready;
    logic [31:0] uart_axi_rdata;
    logic [1:0]  uart_axi_rresp;
    logic        uart_axi_rvalid;
    logic        uart_axi_rready;
    logic [3:0]  uart_axi_awaddr;
    logic        uart_axi_awvalid;
    logic        uart_axi_awready;
    logic [31:0] uart_axi_wdata;
    logic [3:0]  uart_axi_wstrb;
    logic        uart_axi_wvalid;
    logic        uart_axi_wready;
    logic [1:0]  uart_axi_bresp;
    logic        uart_axi_bvalid;
    logic        uart_axi_bready;

    modport master (
        output uart_axi_araddr, uart_axi_arvalid, uart_axi_rready,
        output uart_axi_awaddr, uart_axi_awvalid,
        output uart_axi_wdata, uart_axi_wstrb, uart_axi_wvalid,
        output uart_axi_bready,
        input  uart_axi_arready, uart_axi_rdata, uart_axi_rresp,
        input  uart_axi_rvalid, uart_axi_awready, uart_axi_wready,
        input  uart_axi_bresp, uart_axi_bvalid
    );

    modport slave (
        input  uart_axi_araddr, uart_axi_arvalid, uart_axi_rready,
        input  uart_axi_awaddr, uart_axi_awvalid,
        input  uart_axi_wdata, uart_axi_wstrb, uart_axi_wvalid,
        input  uart_axi_bready,
        output uart_axi_arready, uart_axi_rdata, uart_axi_rresp,
        output uart_axi_rvalid, uart_axi_awready, uart_axi_wready,
        output uart_axi_bresp, uart_axi_bvalid
    );
endinterface

// File: rtl/uart_axi_master.sv
// Simple register-access front end that turns single read/write strobes
// into AXI4-lite transactions; read and write paths run independently.
module uart_axi_master #(
    parameter logic [3:0] WSTRB = 4'b1111
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       r_en,
    input  logic [3:0] r_addr,
    output logic [7:0] r_data,
    output logic       r_busy,
    output logic       r_done,
    output logic       r_err,
    input  logic       w_en,
    input  logic [3:0] w_addr,
    input  logic [7:0] w_data,
    output logic       w_busy,
    output logic       w_done,
    output logic       w_err,
    uart_axi_master_if.master axi
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_AW_W, W_RESP} w_state_e;

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rerr_q, rerr_d;
    logic        rdone_q, rdone_d;

    w_state_e    w_state_q, w_state_d;
    logic [3:0]  awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        werr_q, werr_d;
    logic        wdone_q, wdone_d;
    logic        aw_ok, w_ok;

    // Upper read-data bytes carry nothing for an 8-bit UART.
    logic unused_rdata;
    assign unused_rdata = ^axi.uart_axi_rdata[31:8];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            araddr_q  <= 4'h8;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= 8'h00;
            rerr_q    <= 1'b0;
            rdone_q   <= 1'b0;
            w_state_q <= W_IDLE;
            awaddr_q  <= 4'h4;
            wdata_q   <= 32'h0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            werr_q    <= 1'b0;
            wdone_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            rdone_q   <= rdone_d;
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            werr_q    <= werr_d;
            wdone_q   <= wdone_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        rdone_d   = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (r_en) begin
                    araddr_d  = r_addr;
                    arvalid_d = 1'b1;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (axi.uart_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.uart_axi_rvalid) begin
                    rdata_d   = axi.uart_axi_rdata[7:0];
                    rerr_d    = |axi.uart_axi_rresp;
                    rready_d  = 1'b0;
                    rdone_d   = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        werr_d    = werr_q;
        wdone_d   = 1'b0;
        aw_ok     = 1'b0;
        w_ok      = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (w_en) begin
                    awaddr_d  = w_addr;
                    wdata_d   = {24'h0, w_data};
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    w_state_d = W_AW_W;
                end
            end
            W_AW_W: begin
                // A channel is done once its valid is low or accepted now.
                aw_ok = !awvalid_q || axi.uart_axi_awready;
                w_ok  = !wvalid_q || axi.uart_axi_wready;
                if (axi.uart_axi_awready) awvalid_d = 1'b0;
                if (axi.uart_axi_wready)  wvalid_d  = 1'b0;
                if (aw_ok && w_ok) begin
                    bready_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.uart_axi_bvalid) begin
                    werr_d    = |axi.uart_axi_bresp;
                    bready_d  = 1'b0;
                    wdone_d   = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign r_data = rdata_q;
    assign r_err  = rerr_q;
    assign r_done = rdone_q;
    assign r_busy = (r_state_q != R_IDLE);
    assign w_err  = werr_q;
    assign w_done = wdone_q;
    assign w_busy = (w_state_q != W_IDLE);

    assign axi.uart_axi_araddr  = araddr_q;
    assign axi.uart_axi_arvalid = arvalid_q;
    assign axi.uart_axi_rready  = rready_q;
    assign axi.uart_axi_awaddr  = awaddr_q;
    assign axi.uart_axi_awvalid = awvalid_q;
    assign axi.uart_axi_wdata   = wdata_q;
    assign axi.uart_axi_wstrb   = WSTRB;
    assign axi.uart_axi_wvalid  = wvalid_q;
    assign axi.uart_axi_bready  = bready_q;

endmodule

// File: tb/tb_uart_axi_master.sv
// Directed bench for uart_axi_master: completions go through a scoreboard
// checked by a negedge monitor, alongside cycle-exact directed checks.
module tb_uart_axi_master;

    logic       clk = 1'b0;
    logic       rstn;
    logic       r_en, w_en;
    logic [3:0] r_addr, w_addr;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       r_busy, r_done, r_err;
    logic       w_busy, w_done, w_err;

    int checks = 0;
    int errors = 0;
    int rdone_cnt = 0;
    int wdone_cnt = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } rexp_t;

    rexp_t rq[$];
    logic  wq[$];

    uart_axi_master_if axi ();

    uart_axi_master #(.WSTRB(4'b1111)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .r_en   (r_en),
        .r_addr (r_addr),
        .r_data (r_data),
        .r_busy (r_busy),
        .r_done (r_done),
        .r_err  (r_err),
        .w_en   (w_en),
        .w_addr (w_addr),
        .w_data (w_data),
        .w_busy (w_busy),
        .w_done (w_done),
        .w_err  (w_err),
        .axi    (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic slave_idle();
        axi.uart_axi_arready = 1'b0;
        axi.uart_axi_rvalid  = 1'b0;
        axi.uart_axi_rdata   = 32'h0;
        axi.uart_axi_rresp   = 2'b00;
        axi.uart_axi_awready = 1'b0;
        axi.uart_axi_wready  = 1'b0;
        axi.uart_axi_bvalid  = 1'b0;
        axi.uart_axi_bresp   = 2'b00;
    endtask

    // Monitor: scoreboard pops plus valid/payload hold checks.
    logic        p_rst = 1'b0;
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [3:0]  p_ara, p_awa;
    logic [31:0] p_wd;
    rexp_t       re;
    logic        we;

    always @(negedge clk) begin
        if (rstn && r_done) begin
            rdone_cnt++;
            if (rq.size() == 0) begin
                chk("r_done_unexpected", 32'd0, 32'd1);
            end else begin
                re = rq.pop_front();
                chk("sb_r_data", {24'h0, r_data}, {24'h0, re.d});
                chk("sb_r_err", {31'h0, r_err}, {31'h0, re.e});
            end
        end
        if (rstn && w_done) begin
            wdone_cnt++;
            if (wq.size() == 0) begin
                chk("w_done_unexpected", 32'd0, 32'd1);
            end else begin
                we = wq.pop_front();
                chk("sb_w_err", {31'h0, w_err}, {31'h0, we});
            end
        end
        if (rstn && p_rst) begin
            if (p_arv && !p_arr)
                chk("ar_hold", {axi.uart_axi_arvalid, axi.uart_axi_araddr},
                    {1'b1, p_ara});
            if (p_awv && !p_awr)
                chk("aw_hold", {axi.uart_axi_awvalid, axi.uart_axi_awaddr},
                    {1'b1, p_awa});
            if (p_wv && !p_wr) begin
                chk("w_hold_valid", {31'h0, axi.uart_axi_wvalid}, 32'd1);
                chk("w_hold_data", axi.uart_axi_wdata, p_wd);
            end
        end
        p_rst = rstn;
        p_arv = axi.uart_axi_arvalid;
        p_arr = axi.uart_axi_arready;
        p_ara = axi.uart_axi_araddr;
        p_awv = axi.uart_axi_awvalid;
        p_awr = axi.uart_axi_awready;
        p_awa = axi.uart_axi_awaddr;
        p_wv  = axi.uart_axi_wvalid;
        p_wr  = axi.uart_axi_wready;
        p_wd  = axi.uart_axi_wdata;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn   = 1'b0;
        r_en   = 1'b0;
        w_en   = 1'b0;
        r_addr = 4'h0;
        w_addr = 4'h0;
        w_data = 8'h00;
        slave_idle();
        tick(3);

        chk("rst_arvalid", {31'h0, axi.uart_axi_arvalid}, 32'd0);
        chk("rst_rready", {31'h0, axi.uart_axi_rready}, 32'd0);
        chk("rst_awvalid", {31'h0, axi.uart_axi_awvalid}, 32'd0);
        chk("rst_wvalid", {31'h0, axi.uart_axi_wvalid}, 32'd0);
        chk("rst_bready", {31'h0, axi.uart_axi_bready}, 32'd0);
        chk("rst_araddr", {28'h0, axi.uart_axi_araddr}, 32'h8);
        chk("rst_awaddr", {28'h0, axi.uart_axi_awaddr}, 32'h4);
        chk("rst_wdata", axi.uart_axi_wdata, 32'h0);
        chk("rst_r_data", {24'h0, r_data}, 32'h0);
        chk("rst_flags", {26'h0, r_busy, w_busy, r_done, w_done, r_err, w_err},
            32'h0);
        chk("wstrb", {28'h0, axi.uart_axi_wstrb}, 32'hF);
        rstn = 1'b1;
        tick(1);

        // Minimum-latency read of STAT with an always-ready slave.
        axi.uart_axi_arready = 1'b1;
        axi.uart_axi_rvalid  = 1'b1;
        axi.uart_axi_rdata   = 32'h0000_0015;
        r_addr = 4'h8;
        r_en   = 1'b1;
        rq.push_back('{8'h15, 1'b0});
        tick(1);
        r_en = 1'b0;
        chk("t1_c1_arvalid", {31'h0, axi.uart_axi_arvalid}, 32'd1);
        chk("t1_c1_araddr", {28'h0, axi.uart_axi_araddr}, 32'h8);
        chk("t1_c1_busy", {31'h0, r_busy}, 32'd1);
        tick(1);
        chk("t1_c2_rready", {31'h0, axi.uart_axi_rready}, 32'd1);
        chk("t1_c2_arvalid", {31'h0, axi.uart_axi_arvalid}, 32'd0);
        tick(1);
        chk("t1_c3_done", {30'h0, r_done, r_busy}, 32'b10);
        tick(1);
        chk("t1_c4_done_low", {31'h0, r_done}, 32'd0);
        chk("t1_c4_data_held", {24'h0, r_data}, 32'h15);
        slave_idle();
        tick(1);

        // Write with split AW/W handshakes and SLVERR response.
        axi.uart_axi_bvalid = 1'b1;
        axi.uart_axi_bresp  = 2'd2;
        w_addr = 4'h4;
        w_data = 8'h41;
        w_en   = 1'b1;
        wq.push_back(1'b1);
        tick(1);
        w_en = 1'b0;
        axi.uart_axi_awready = 1'b1;
        chk("t2_c1_valids", {30'h0, axi.uart_axi_awvalid,
            axi.uart_axi_wvalid}, 32'b11);
        chk("t2_c1_awaddr", {28'h0, axi.uart_axi_awaddr}, 32'h4);
        chk("t2_c1_wdata", axi.uart_axi_wdata, 32'h41);
        tick(1);
        axi.uart_axi_awready = 1'b0;
        chk("t2_c2_valids", {30'h0, axi.uart_axi_awvalid,
            axi.uart_axi_wvalid}, 32'b01);
        tick(1);
        chk("t2_c3_wdata", axi.uart_axi_wdata, 32'h41);
        chk("t2_c3_bready", {31'h0, axi.uart_axi_bready}, 32'd0);
        tick(1);
        axi.uart_axi_wready = 1'b1;
        chk("t2_c4_wvalid", {31'h0, axi.uart_axi_wvalid}, 32'd1);
        tick(1);
        axi.uart_axi_wready = 1'b0;
        chk("t2_c5_state", {30'h0, axi.uart_axi_wvalid,
            axi.uart_axi_bready}, 32'b01);
        tick(1);
        chk("t2_c6_done", {29'h0, w_done, w_err, w_busy}, 32'b110);
        slave_idle();
        tick(1);
        chk("t2_c7_done_low", {31'h0, w_done}, 32'd0);
        chk("t2_wdone_cnt", wdone_cnt, 32'd1);

        // AR stalled for 10 cycles while r_en keeps toggling.
        axi.uart_axi_rvalid = 1'b1;
        axi.uart_axi_rdata  = 32'h0000_005A;
        r_addr = 4'h0;
        r_en   = 1'b1;
        rq.push_back('{8'h5A, 1'b0});
        tick(1);
        r_addr = 4'h8;
        for (int i = 0; i < 10; i++) begin
            r_en = i[0];
            chk("t3_stall", {27'h0, axi.uart_axi_arvalid,
                axi.uart_axi_araddr}, 32'h10);
            tick(1);
        end
        r_en = 1'b0;
        axi.uart_axi_arready = 1'b1;
        tick(1);
        axi.uart_axi_arready = 1'b0;
        tick(1);
        chk("t3_done", {31'h0, r_done}, 32'd1);
        tick(3);
        chk("t3_rdone_cnt", rdone_cnt, 32'd2);
        chk("t3_idle", {30'h0, r_busy, axi.uart_axi_arvalid}, 32'd0);
        slave_idle();

        // Simultaneous read and write.
        axi.uart_axi_arready = 1'b1;
        axi.uart_axi_rvalid  = 1'b1;
        axi.uart_axi_rdata   = 32'hABCD_EF33;
        axi.uart_axi_rresp   = 2'd2;
        axi.uart_axi_awready = 1'b1;
        axi.uart_axi_wready  = 1'b1;
        axi.uart_axi_bvalid  = 1'b1;
        axi.uart_axi_bresp   = 2'd0;
        r_addr = 4'h0;
        w_addr = 4'hC;
        w_data = 8'h9C;
        r_en   = 1'b1;
        w_en   = 1'b1;
        rq.push_back('{8'h33, 1'b1});
        wq.push_back(1'b0);
        tick(1);
        r_en = 1'b0;
        w_en = 1'b0;
        chk("t4_awaddr", {28'h0, axi.uart_axi_awaddr}, 32'hC);
        chk("t4_wdata", axi.uart_axi_wdata, 32'h9C);
        chk("t4_araddr", {28'h0, axi.uart_axi_araddr}, 32'h0);
        tick(2);
        chk("t4_both_done", {30'h0, r_done, w_done}, 32'b11);
        tick(2);
        chk("t4_rdone_cnt", rdone_cnt, 32'd3);
        chk("t4_wdone_cnt", wdone_cnt, 32'd2);
        slave_idle();

        // Reset with read in R_DATA and write in W_AW_W.
        axi.uart_axi_arready = 1'b1;
        r_addr = 4'h0;
        w_addr = 4'hC;
        w_data = 8'h55;
        r_en   = 1'b1;
        w_en   = 1'b1;
        tick(1);
        r_en = 1'b0;
        w_en = 1'b0;
        tick(1);
        chk("t5_pre", {29'h0, axi.uart_axi_rready, axi.uart_axi_awvalid,
            axi.uart_axi_wvalid}, 32'b111);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        chk("t5_valids", {27'h0, axi.uart_axi_arvalid, axi.uart_axi_rready,
            axi.uart_axi_awvalid, axi.uart_axi_wvalid,
            axi.uart_axi_bready}, 32'h0);
        chk("t5_busy", {30'h0, r_busy, w_busy}, 32'h0);
        chk("t5_addrs", {24'h0, axi.uart_axi_araddr, axi.uart_axi_awaddr},
            32'h84);
        chk("t5_wdata", axi.uart_axi_wdata, 32'h0);
        chk("t5_r_data", {24'h0, r_data}, 32'h0);
        chk("t5_errs", {30'h0, r_err, w_err}, 32'h0);
        axi.uart_axi_rvalid = 1'b1;
        axi.uart_axi_rdata  = 32'h0000_0077;
        axi.uart_axi_rresp  = 2'd0;
        r_addr = 4'h8;
        r_en   = 1'b1;
        rq.push_back('{8'h77, 1'b0});
        tick(1);
        r_en = 1'b0;
        tick(2);
        chk("t5_read_done", {31'h0, r_done}, 32'd1);
        tick(2);
        chk("t5_rdone_cnt", rdone_cnt, 32'd4);
        slave_idle();

        // Back-to-back reads with r_en held through the done cycle.
        axi.uart_axi_arready = 1'b1;
        axi.uart_axi_rvalid  = 1'b1;
        axi.uart_axi_rdata   = 32'h0000_0021;
        r_addr = 4'h0;
        r_en   = 1'b1;
        rq.push_back('{8'h21, 1'b0});
        rq.push_back('{8'h22, 1'b0});
        tick(3);
        chk("t6_first_done", {31'h0, r_done}, 32'd1);
        axi.uart_axi_rdata = 32'h0000_0022;
        tick(1);
        r_en = 1'b0;
        chk("t6_rearm", {31'h0, axi.uart_axi_arvalid}, 32'd1);
        tick(2);
        chk("t6_second_done", {31'h0, r_done}, 32'd1);
        tick(3);
        slave_idle();

        chk("end_rq_empty", rq.size(), 32'd0);
        chk("end_wq_empty", wq.size(), 32'd0);
        chk("end_rdone_cnt", rdone_cnt, 32'd6);
        chk("end_wdone_cnt", wdone_cnt, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
